// File: rtl/readout_sequencer.sv
// Frame sequencer for the pixel-array ADC: erase, exposure, single-slope
// conversion (Gray ramp counter released) and row-by-row readout.
module readout_sequencer #(
   parameter int WIDTH        = 8,
   parameter int ROWS         = 2,
   parameter int ERASE_CYCLES = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [7:0]      expose_cycles,
   output logic            busy,
   output logic            erase,
   output logic            expose,
   output logic            convert,
   output logic            gc_reset,
   output logic            gc_clk_en,
   output logic [ROWS-1:0] read,
   output logic            data_valid,
   output logic            frame_done
);

   localparam int CONV  = 1 << WIDTH;
   localparam int MAX_A = (ERASE_CYCLES > 255) ? ERASE_CYCLES : 255;
   localparam int MAXV  = ((MAX_A > CONV) ? MAX_A : CONV) + 1;
   localparam int CW    = $clog2(MAXV + 1);
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      ERASE,
      EXPOSE,
      CONVERT,
      READOUT
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [RW-1:0]   row, row_nx;
   logic [7:0]      exp_q, exp_nx;
   logic            done_q, done_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         row    <= '0;
         exp_q  <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         row    <= row_nx;
         exp_q  <= exp_nx;
         done_q <= done_nx;
      end
   end

   // cnt holds the remaining cycles of the current phase minus one
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      row_nx   = row;
      exp_nx   = exp_q;
      done_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = ERASE;
               cnt_nx   = CW'(ERASE_CYCLES - 1);
               exp_nx   = (expose_cycles == 8'd0) ? 8'd1 : expose_cycles;
            end
         end
         ERASE: begin
            if (cnt == '0) begin
               state_nx = EXPOSE;
               cnt_nx   = CW'(exp_q) - CW'(1);
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         EXPOSE: begin
            if (cnt == '0) begin
               state_nx = CONVERT;
               cnt_nx   = CW'(CONV - 1);
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         CONVERT: begin
            if (cnt == '0) begin
               state_nx = READOUT;
               cnt_nx   = CW'(1);
               row_nx   = '0;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         READOUT: begin
            if (cnt == '0) begin
               if (row == RW'(ROWS - 1)) begin
                  state_nx = IDLE;
                  row_nx   = '0;
                  done_nx  = 1'b1;
               end else begin
                  row_nx = row + RW'(1);
                  cnt_nx = CW'(1);
               end
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      erase      = (state == ERASE);
      expose     = (state == EXPOSE);
      convert    = (state == CONVERT);
      gc_clk_en  = (state == CONVERT);
      gc_reset   = (state != CONVERT);
      read       = '0;
      if (state == READOUT) read[row] = 1'b1;
      data_valid = (state == READOUT) && (cnt == '0);
      frame_done = done_q;
   end

endmodule

// File: tb/tb_readout_sequencer.sv
// Self-checking bench for readout_sequencer: timeline model plus directed scenarios.
module tb_readout_sequencer;

   localparam int W  = 8;
   localparam int R  = 2;
   localparam int EC = 5;
   localparam int CV = 1 << W;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [7:0]   expose_cycles = 8'd0;
   logic         busy, erase, expose, convert, gc_reset, gc_clk_en;
   logic [R-1:0] read;
   logic         data_valid, frame_done;

   int compared = 0;
   int mismatched = 0;

   readout_sequencer #(.WIDTH(W), .ROWS(R), .ERASE_CYCLES(EC)) dut (
      .clk(clk), .reset(reset), .start(start), .expose_cycles(expose_cycles),
      .busy(busy), .erase(erase), .expose(expose), .convert(convert),
      .gc_reset(gc_reset), .gc_clk_en(gc_clk_en), .read(read),
      .data_valid(data_valid), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: a frame accepted at edge fs puts cycle k=1 right after that edge.
   int cyc = 0;
   int fs = 0;
   int e_len = 0;
   int l_len = 0;
   bit have_frame = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         have_frame <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (start && (!have_frame || (cyc + 1 - fs >= l_len + 1))) begin
            have_frame <= 1'b1;
            fs         <= cyc + 1;
            e_len      <= (expose_cycles == 8'd0) ? 1 : int'(expose_cycles);
            l_len      <= EC + ((expose_cycles == 8'd0) ? 1 : int'(expose_cycles)) + CV + 2 * R;
         end
      end
   end

   always @(posedge clk) begin
      int k, j, nph;
      logic [R-1:0] e_read;
      bit e_er, e_ex, e_cv;
      #1;
      if (!reset) begin
         k = have_frame ? (cyc - fs + 1) : 0;
         e_er = (k >= 1) && (k <= EC);
         e_ex = (k > EC) && (k <= EC + e_len);
         e_cv = (k > EC + e_len) && (k <= EC + e_len + CV);
         j = k - (EC + e_len + CV) - 1;
         e_read = '0;
         if (have_frame && j >= 0 && j < 2 * R) e_read[j / 2] = 1'b1;
         chk("busy", int'(busy), int'(have_frame && k >= 1 && k <= l_len));
         chk("erase", int'(erase), int'(e_er));
         chk("expose", int'(expose), int'(e_ex));
         chk("convert", int'(convert), int'(e_cv));
         chk("gc_clk_en", int'(gc_clk_en), int'(e_cv));
         chk("gc_reset", int'(gc_reset), int'(!e_cv));
         chk("read", int'(read), int'(e_read));
         chk("data_valid", int'(data_valid), int'(have_frame && j >= 0 && j < 2 * R && (j % 2 == 1)));
         chk("frame_done", int'(frame_done), int'(have_frame && k == l_len + 1));
         nph = int'(erase) + int'(expose) + int'(convert) + int'(read != '0);
         chk("inv_gc_both", int'(gc_reset & gc_clk_en), 0);
         chk("inv_read_onehot", int'($onehot0(read)), 1);
         chk("inv_one_phase", int'(nph <= 1), 1);
      end
   end

   logic [R-1:0] rd_seq [0:7];
   logic         dv_seq [0:7];

   // Called at the negedge holding frame cycle k=1; returns at the frame_done sample.
   task automatic measure(input int mode, output int ner, output int nex, output int ncv,
                          output int ndone, output int nrd);
      ner = 0; nex = 0; ncv = 0; ndone = 0; nrd = 0;
      for (int i = 1; i <= 2000; i++) begin
         ner += int'(erase);
         nex += int'(expose);
         ncv += int'(convert);
         if (read != '0 && nrd < 8) begin
            rd_seq[nrd] = read;
            dv_seq[nrd] = data_valid;
            nrd++;
         end
         if (frame_done) begin
            ndone = i;
            break;
         end
         if (mode == 1) begin
            if (i == 8 || i == 100) begin
               start = 1'b1;
               expose_cycles = 8'd50;
            end else begin
               start = 1'b0;
            end
         end
         @(negedge clk);
      end
      if (ndone == 0) chk("frame_timeout", 0, 1);
   endtask

   task automatic begin_frame(input logic [7:0] e, input bit hold);
      @(negedge clk);
      start = 1'b1;
      expose_cycles = e;
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   initial begin
      int ner, nex, ncv, ndone, nrd, n;
      #23;
      chk("rst_busy", int'(busy), 0);
      chk("rst_gc_reset", int'(gc_reset), 1);
      chk("rst_read", int'(read), 0);
      chk("rst_done", int'(frame_done), 0);
      @(negedge clk);
      reset = 1'b0;

      // Basic frame
      begin_frame(8'd10, 1'b0);
      measure(0, ner, nex, ncv, ndone, nrd);
      chk("basic_erase_len", ner, 5);
      chk("basic_expose_len", nex, 10);
      chk("basic_convert_len", ncv, 256);
      chk("basic_done_at", ndone, 276);
      chk("basic_read_cnt", nrd, 4);
      chk("basic_rd0", int'(rd_seq[0]), 1);
      chk("basic_rd1", int'(rd_seq[1]), 1);
      chk("basic_rd2", int'(rd_seq[2]), 2);
      chk("basic_rd3", int'(rd_seq[3]), 2);
      chk("basic_dv", {28'd0, dv_seq[3], dv_seq[2], dv_seq[1], dv_seq[0]}, 4'b1010);
      repeat (3) @(negedge clk);

      // Zero exposure
      begin_frame(8'd0, 1'b0);
      measure(0, ner, nex, ncv, ndone, nrd);
      chk("zero_expose_len", nex, 1);
      chk("zero_done_at", ndone, 5 + 1 + 256 + 4 + 1);
      repeat (2) @(negedge clk);

      // Start pulses and exposure change while busy
      begin_frame(8'd3, 1'b0);
      measure(1, ner, nex, ncv, ndone, nrd);
      chk("busy_expose_len", nex, 3);
      chk("busy_done_at", ndone, 5 + 3 + 256 + 4 + 1);
      repeat (3) @(negedge clk);
      chk("busy_no_second_frame", int'(busy), 0);

      // Reset in the middle of conversion
      begin_frame(8'd1, 1'b0);
      n = 0;
      for (int i = 0; i < 2000 && n < 100; i++) begin
         n += int'(convert);
         if (n < 100) @(negedge clk);
      end
      chk("rst_reached_convert", n, 100);
      #2 reset = 1'b1;
      #1;
      chk("async_convert", int'(convert), 0);
      chk("async_gc_clk_en", int'(gc_clk_en), 0);
      chk("async_gc_reset", int'(gc_reset), 1);
      chk("async_busy", int'(busy), 0);
      @(negedge clk);
      reset = 1'b0;
      begin_frame(8'd2, 1'b0);
      measure(0, ner, nex, ncv, ndone, nrd);
      chk("after_rst_convert_len", ncv, 256);
      chk("after_rst_done_at", ndone, 5 + 2 + 256 + 4 + 1);
      repeat (2) @(negedge clk);

      // Continuous start
      begin_frame(8'd4, 1'b1);
      measure(0, ner, nex, ncv, ndone, nrd);
      chk("cont_done_at", ndone, 5 + 4 + 256 + 4 + 1);
      chk("cont_done_idle", int'(busy), 0);
      @(negedge clk);
      chk("cont_next_erase", int'(erase), 1);
      measure(0, ner, nex, ncv, ndone, nrd);
      chk("cont2_erase_len", ner, 5);
      chk("cont2_done_at", ndone, 5 + 4 + 256 + 4 + 1);
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 2000 && busy !== 1'b0; i++) begin
         @(negedge clk);
         n++;
      end
      chk("cont_final_idle", int'(busy), 0);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
